gate_truth_checker: RTL

Synthesizable self-checking stimulus sequencer that sits directly upstream of a two-input combinational gate (e.g. `andGate`). It drives the gate inputs through all four input combinations, waits a programmable settle time, samples the gate output, and compares it against an expected truth table. It reports a pass/fail verdict, an error count and the first failing vector, so the hardware does the job the interactive testbench does today.

---
 rtl/gate_test_pkg.sv | 18 +
 rtl/gate_settle_timer.sv | 39 +++
 rtl/gate_truth_checker.sv | 95 +++++++++
 3 files changed

// File: rtl/gate_test_pkg.sv
// Shared definitions for the gate truth-table checker: FSM state encoding
// and reference truth tables for common two-input gates.
package gate_test_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Truth tables are indexed by {a,b}: bit 0 is a=0,b=0 and bit 3 is a=1,b=1.
  localparam logic [3:0] AND_TT  = 4'b1000;
  localparam logic [3:0] OR_TT   = 4'b1110;
  localparam logic [3:0] XOR_TT  = 4'b0110;
  localparam logic [3:0] NAND_TT = 4'b0111;

endpackage

// File: rtl/gate_settle_timer.sv
// Settle-time counter: counts up from 0 while enabled and flags the last
// cycle of the settle window (count == SETTLE_CYCLES-1).
module gate_settle_timer
  import gate_test_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(SETTLE_CYCLES - 1);

  generate
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("gate_settle_timer: SETTLE_CYCLES must be at least 1");
    end
  endgenerate

  logic [W-1:0] count;

  // Counter holds at the terminal value; the FSM leaves SETTLE on that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/gate_truth_checker.sv
// Drives all four input combinations into a two-input gate, samples its output
// after a settle window and reports a pass/fail verdict against EXPECT_TT.
module gate_truth_checker
  import gate_test_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [3:0] EXPECT_TT     = AND_TT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  input  logic       y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] fail_vec
);

  state_t     state;
  state_t     state_next;
  logic [1:0] vec;
  logic       first_seen;
  logic       expired;
  logic       launch;
  logic       mismatch;

  assign launch   = start && ((state == IDLE) || (state == DONE));
  assign mismatch = (state == SAMPLE) && (y_in != EXPECT_TT[vec]);

  gate_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != SETTLE),
    .en     (state == SETTLE),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = SETTLE;
      SETTLE:     if (expired) state_next = SAMPLE;
      SAMPLE:     state_next = (vec == 2'd3) ? DONE : SETTLE;
      default:    state_next = IDLE;
    endcase
  end

  // Only the first mismatching vector is latched into fail_vec.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec        <= 2'd0;
      err_count  <= 3'd0;
      fail_vec   <= 2'd0;
      first_seen <= 1'b0;
    end else if (launch) begin
      vec        <= 2'd0;
      err_count  <= 3'd0;
      fail_vec   <= 2'd0;
      first_seen <= 1'b0;
    end else if (state == SAMPLE) begin
      if (mismatch) begin
        err_count <= err_count + 3'd1;
        if (!first_seen) begin
          fail_vec   <= vec;
          first_seen <= 1'b1;
        end
      end
      if (vec != 2'd3) begin
        vec <= vec + 2'd1;
      end
    end
  end

  always_comb begin
    busy  = (state == SETTLE) || (state == SAMPLE);
    done  = (state == DONE);
    a_out = busy ? vec[1] : 1'b0;
    b_out = busy ? vec[0] : 1'b0;
    pass  = done && (err_count == 3'd0);
  end

endmodule
